// File: rtl/alarm_pkg.sv
// Shared types and keypad constants for the alarm sequencer.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    // Keypad codes, matching the key_15 / key_16 defines.
    localparam logic [4:0] KEY_SNOOZE_C = 5'd15;
    localparam logic [4:0] KEY_STOP_C   = 5'd16;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Timekeeping/keypad inputs and ring/status outputs of the alarm sequencer.
interface alarm_ctrl_if;

    logic       sec_tick;
    logic [4:0] key_code;
    logic [4:0] cur_h;
    logic [5:0] cur_m;
    logic [4:0] alm_h;
    logic [5:0] alm_m;
    logic       alarm_en;
    logic       ring;
    logic [1:0] state_o;
    logic [1:0] snooze_cnt_o;

    // Master drives time, keys and enable; slave (the sequencer) drives status.
    modport master (
        output sec_tick, key_code, cur_h, cur_m, alm_h, alm_m, alarm_en,
        input  ring, state_o, snooze_cnt_o
    );

    modport slave (
        input  sec_tick, key_code, cur_h, cur_m, alm_h, alm_m, alarm_en,
        output ring, state_o, snooze_cnt_o
    );

endinterface

// File: rtl/alarm_ctrl_key_event.sv
// Keypad edge detector: one pulse per new non-zero code, so a held key fires once.
module key_event
    import alarm_pkg::*;
#(
    parameter logic [4:0] KEY_SNOOZE = KEY_SNOOZE_C,
    parameter logic [4:0] KEY_STOP   = KEY_STOP_C
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [4:0] key_code_i,
    output logic       snooze_ev_o,
    output logic       stop_ev_o
);

    logic [4:0] key_q;
    logic       ev;

    // Previous key code, used to detect a change.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            key_q <= 5'd0;
        end else begin
            key_q <= key_code_i;
        end
    end

    // Event on a change to any non-zero code; decode the two codes of interest.
    always_comb begin
        ev          = (key_code_i != key_q) && (key_code_i != 5'd0);
        snooze_ev_o = ev && (key_code_i == KEY_SNOOZE);
        stop_ev_o   = ev && (key_code_i == KEY_STOP);
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: match-edge trigger, ring timeout, snooze and stop handling.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter logic [4:0]  KEY_SNOOZE = KEY_SNOOZE_C,
    parameter logic [4:0]  KEY_STOP   = KEY_STOP_C
) (
    input  logic          mclk,
    input  logic          rst_n,
    alarm_ctrl_if.slave   bus
);

    localparam int unsigned MaxSec = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int unsigned TimerW = $clog2(MaxSec + 1);

    alarm_state_t      state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              match, match_q, trigger;
    logic              ring_q;
    logic              snooze_ev, stop_ev;

    key_event #(
        .KEY_SNOOZE (KEY_SNOOZE),
        .KEY_STOP   (KEY_STOP)
    ) u_key_event (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .key_code_i  (bus.key_code),
        .snooze_ev_o (snooze_ev),
        .stop_ev_o   (stop_ev)
    );

    // Trigger only on the rising edge of time equality.
    always_comb begin
        match   = (bus.cur_h == bus.alm_h) && (bus.cur_m == bus.alm_m);
        trigger = match && !match_q;
    end

    // State, timer, snooze count, match history and registered ring.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= 2'd0;
            match_q <= 1'b0;
            ring_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            match_q <= match;
            ring_q  <= (state_d == RINGING);
        end
    end

    // Next state; disarm wins, then stop > snooze > timeout while ringing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (bus.sec_tick && (state_q == RINGING || state_q == SNOOZE)) begin
            timer_d = timer_q + TimerW'(1);
        end

        if (!bus.alarm_en) begin
            state_d = IDLE;
            timer_d = '0;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    timer_d = '0;
                end
                ARMED: begin
                    if (trigger) begin
                        state_d = RINGING;
                        timer_d = '0;
                        cnt_d   = 2'd0;
                    end
                end
                RINGING: begin
                    if (stop_ev) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end else if (snooze_ev && (cnt_q < 2'(MAX_SNOOZE))) begin
                        state_d = SNOOZE;
                        timer_d = '0;
                        cnt_d   = cnt_q + 2'd1;
                    end else if (bus.sec_tick && (timer_q == TimerW'(RING_SEC - 1))) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end
                end
                SNOOZE: begin
                    if (stop_ev) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end else if (bus.sec_tick && (timer_q == TimerW'(SNOOZE_SEC - 1))) begin
                        state_d = RINGING;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Outputs straight from registers so ring and state_o stay aligned.
    always_comb begin
        bus.ring         = ring_q;
        bus.state_o      = state_q;
        bus.snooze_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short ring/snooze times.
module tb_alarm_ctrl;

    logic mclk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .RING_SEC   (5),
        .SNOOZE_SEC (3),
        .MAX_SNOOZE (2),
        .KEY_SNOOZE (5'd15),
        .KEY_STOP   (5'd16)
    ) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit later.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    // One second: a one-cycle tick followed by nine quiet cycles.
    task automatic sec();
        bus.sec_tick = 1'b1;
        cyc(1);
        bus.sec_tick = 1'b0;
        cyc(9);
    endtask

    // Re-create a match rising edge at 07:30.
    task automatic retrigger();
        bus.cur_m = 6'd31;
        cyc(1);
        bus.cur_m = 6'd30;
        cyc(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.alarm_en = 1'b1;
        cyc(2);
        n_vec++;
        if (bus.state_o !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state got %0d want 0", bus.state_o);
        end
        n_vec++;
        if (bus.ring !== 1'b0 || bus.snooze_cnt_o !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got ring=%0b cnt=%0d want 0/0", bus.ring,
                     bus.snooze_cnt_o);
        end
        rst_n = 1'b1;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL armed_after_reset got %0d want 1", bus.state_o);
        end
    endtask

    task automatic test_ring_timeout();
        bus.cur_h = 5'd7;
        bus.cur_m = 6'd29;
        cyc(2);
        n_vec++;
        if (bus.ring !== 1'b0) begin
            n_bad++;
            $display("FAIL no_ring_before_match got %0b want 0", bus.ring);
        end
        bus.cur_m = 6'd30;
        cyc(1);
        n_vec++;
        if (bus.ring !== 1'b1 || bus.state_o !== 2'd2) begin
            n_bad++;
            $display("FAIL ring_on_match got ring=%0b st=%0d want 1/2", bus.ring, bus.state_o);
        end
        repeat (4) sec();
        n_vec++;
        if (bus.ring !== 1'b1) begin
            n_bad++;
            $display("FAIL ring_after_4s got %0b want 1", bus.ring);
        end
        sec();
        n_vec++;
        if (bus.ring !== 1'b0 || bus.state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL timeout got ring=%0b st=%0d want 0/1", bus.ring, bus.state_o);
        end
    endtask

    task automatic test_snooze();
        retrigger();
        bus.key_code = 5'd15;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd3 || bus.snooze_cnt_o !== 2'd1) begin
            n_bad++;
            $display("FAIL snooze_entry got st=%0d cnt=%0d want 3/1", bus.state_o,
                     bus.snooze_cnt_o);
        end
        cyc(49);
        n_vec++;
        if (bus.state_o !== 2'd3 || bus.snooze_cnt_o !== 2'd1) begin
            n_bad++;
            $display("FAIL held_key_single got st=%0d cnt=%0d want 3/1", bus.state_o,
                     bus.snooze_cnt_o);
        end
        bus.key_code = 5'd0;
        cyc(1);
        repeat (2) sec();
        n_vec++;
        if (bus.state_o !== 2'd3 || bus.ring !== 1'b0) begin
            n_bad++;
            $display("FAIL snooze_2s got st=%0d ring=%0b want 3/0", bus.state_o, bus.ring);
        end
        sec();
        n_vec++;
        if (bus.ring !== 1'b1 || bus.state_o !== 2'd2 || bus.snooze_cnt_o !== 2'd1) begin
            n_bad++;
            $display("FAIL re_ring got ring=%0b st=%0d cnt=%0d want 1/2/1", bus.ring,
                     bus.state_o, bus.snooze_cnt_o);
        end
    endtask

    task automatic test_max_snooze_stop();
        bus.key_code = 5'd15;
        cyc(1);
        bus.key_code = 5'd0;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd3 || bus.snooze_cnt_o !== 2'd2) begin
            n_bad++;
            $display("FAIL second_snooze got st=%0d cnt=%0d want 3/2", bus.state_o,
                     bus.snooze_cnt_o);
        end
        repeat (3) sec();
        bus.key_code = 5'd15;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd2 || bus.snooze_cnt_o !== 2'd2 || bus.ring !== 1'b1) begin
            n_bad++;
            $display("FAIL snooze_limit got st=%0d cnt=%0d ring=%0b want 2/2/1", bus.state_o,
                     bus.snooze_cnt_o, bus.ring);
        end
        bus.key_code = 5'd0;
        cyc(1);
        bus.key_code = 5'd16;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd1 || bus.ring !== 1'b0 || bus.snooze_cnt_o !== 2'd2) begin
            n_bad++;
            $display("FAIL stop got st=%0d ring=%0b cnt=%0d want 1/0/2", bus.state_o, bus.ring,
                     bus.snooze_cnt_o);
        end
        bus.key_code = 5'd0;
        cyc(1);
    endtask

    task automatic test_enable_on_match();
        bus.alarm_en = 1'b0;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd0 || bus.snooze_cnt_o !== 2'd0) begin
            n_bad++;
            $display("FAIL disarm got st=%0d cnt=%0d want 0/0", bus.state_o, bus.snooze_cnt_o);
        end
        bus.alarm_en = 1'b1;
        cyc(6);
        n_vec++;
        if (bus.state_o !== 2'd1 || bus.ring !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_on_match got st=%0d ring=%0b want 1/0", bus.state_o, bus.ring);
        end
        retrigger();
        n_vec++;
        if (bus.ring !== 1'b1) begin
            n_bad++;
            $display("FAIL next_day_ring got %0b want 1", bus.ring);
        end
        bus.key_code = 5'd5;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd2 || bus.ring !== 1'b1) begin
            n_bad++;
            $display("FAIL other_key got st=%0d ring=%0b want 2/1", bus.state_o, bus.ring);
        end
        bus.key_code = 5'd0;
        cyc(1);
    endtask

    task automatic test_disable_and_reset();
        bus.key_code = 5'd15;
        cyc(1);
        bus.key_code = 5'd0;
        cyc(1);
        n_vec++;
        if (bus.snooze_cnt_o !== 2'd1) begin
            n_bad++;
            $display("FAIL cnt_after_retrigger got %0d want 1", bus.snooze_cnt_o);
        end
        bus.alarm_en = 1'b0;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd0 || bus.snooze_cnt_o !== 2'd0 || bus.ring !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_mid got st=%0d cnt=%0d ring=%0b want 0/0/0", bus.state_o,
                     bus.snooze_cnt_o, bus.ring);
        end
        bus.alarm_en = 1'b1;
        bus.cur_h = 5'd8;
        bus.cur_m = 6'd0;
        cyc(2);
        // Moving the alarm onto the current time is an ordinary match edge.
        bus.alm_h = 5'd8;
        bus.alm_m = 6'd0;
        cyc(1);
        n_vec++;
        if (bus.ring !== 1'b1 || bus.state_o !== 2'd2) begin
            n_bad++;
            $display("FAIL alarm_change got ring=%0b st=%0d want 1/2", bus.ring, bus.state_o);
        end
        bus.key_code = 5'd15;
        cyc(1);
        bus.key_code = 5'd0;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd0 || bus.ring !== 1'b0 || bus.snooze_cnt_o !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_mid_snooze got st=%0d ring=%0b cnt=%0d want 0/0/0",
                     bus.state_o, bus.ring, bus.snooze_cnt_o);
        end
        rst_n = 1'b1;
        cyc(1);
        n_vec++;
        if (bus.state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL rearm_after_reset got %0d want 1", bus.state_o);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.sec_tick = 1'b0;
        bus.key_code = 5'd0;
        bus.cur_h    = 5'd0;
        bus.cur_m    = 6'd0;
        bus.alm_h    = 5'd7;
        bus.alm_m    = 6'd30;
        bus.alarm_en = 1'b0;
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_max_snooze_stop();
        test_enable_on_match();
        test_disable_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
